// File: rtl/seg_scan_if.sv
// Display bus bundle between the result registers (master) and the scan driver (slave).
interface seg_scan_if #(
   parameter int unsigned NUM_DIGITS = 4
) ();

   logic                    load;
   logic [4*NUM_DIGITS-1:0] data_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic                    lz_en;
   logic [6:0]              seg_out;
   logic                    dp_out;
   logic [NUM_DIGITS-1:0]   an_out;
   logic                    frame_tick;

   modport master (
      output load, data_in, dp_in, blank_in, lz_en,
      input  seg_out, dp_out, an_out, frame_tick
   );

   modport slave (
      input  load, data_in, dp_in, blank_in, lz_en,
      output seg_out, dp_out, an_out, frame_tick
   );

endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment driver: captures a packed hex word, scans one
// shared active-low segment bus across NUM_DIGITS digits with guard interval, per-digit
// dp/blanking and leading-zero suppression. All outputs are registered.
module seg_scan_driver #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned GUARD_CYCLES = 2
) (
   input logic       clk_in,
   input logic       rst,
   seg_scan_if.slave bus
);

   localparam int unsigned CntW = $clog2(REFRESH_DIV);
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
   localparam logic [CntW-1:0] GuardVal = CntW'(GUARD_CYCLES);
   localparam logic [IdxW-1:0] IdxMax   = IdxW'(NUM_DIGITS - 1);

   // Active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [4*NUM_DIGITS-1:0] data_q;
   logic [NUM_DIGITS-1:0]   dp_q;
   logic [NUM_DIGITS-1:0]   blank_q;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_out_q, dp_out_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    tick_q, tick_d;

   logic [NUM_DIGITS-1:0]   upper_zero;
   logic [NUM_DIGITS-1:0]   dark;
   logic                    run_zero;
   logic [3:0]              sel_nib;
   logic                    sel_dp;
   logic                    sel_dark;
   logic                    guard;

   // Holding registers capture the display word on the load strobe
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         dp_q    <= '0;
         blank_q <= '0;
      end else if (bus.load) begin
         data_q  <= bus.data_in;
         dp_q    <= bus.dp_in;
         blank_q <= bus.blank_in;
      end
   end

   // upper_zero[k]: digits k..NUM_DIGITS-1 are all zero
   always_comb begin
      run_zero   = 1'b1;
      upper_zero = '0;
      for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
         run_zero      = run_zero & (data_q[4*k +: 4] == 4'h0);
         upper_zero[k] = run_zero;
      end
   end

   // Per-digit dark mask; digit 0 is never zero-suppressed, lz_en is used live
   always_comb begin
      dark = blank_q;
      for (int k = 1; k < int'(NUM_DIGITS); k++) begin
         dark[k] = blank_q[k] | (bus.lz_en & upper_zero[k]);
      end
   end

   // Mux the currently scanned digit's nibble, dp request and dark flag
   always_comb begin
      sel_nib  = 4'h0;
      sel_dp   = 1'b0;
      sel_dark = 1'b0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         if (idx_q == IdxW'(k)) begin
            sel_nib  = data_q[4*k +: 4];
            sel_dp   = dp_q[k];
            sel_dark = dark[k];
         end
      end
   end

   // Prescaler and digit index advance, plus next-state of the registered outputs
   always_comb begin
      cnt_d    = cnt_q + CntW'(1);
      idx_d    = idx_q;
      if (cnt_q == CntMax) begin
         cnt_d = '0;
         idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
      end

      guard    = (cnt_q < GuardVal);
      an_d     = '1;
      seg_d    = 7'h7F;
      dp_out_d = 1'b1;
      if (!guard) begin
         for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IdxW'(k)) an_d[k] = 1'b0;
         end
         if (!sel_dark) begin
            seg_d    = hex_to_seg(sel_nib);
            dp_out_d = ~sel_dp;
         end
      end
      tick_d = (cnt_q == CntMax) && (idx_q == IdxMax);
   end

   // Scan state and output registers; reset blanks the display immediately
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         seg_q    <= 7'h7F;
         dp_out_q <= 1'b1;
         an_q     <= '1;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         seg_q    <= seg_d;
         dp_out_q <= dp_out_d;
         an_q     <= an_d;
         tick_q   <= tick_d;
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.dp_out     = dp_out_q;
   assign bus.an_out     = an_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (4 digits, 4-cycle slots, 1 guard cycle).
module tb_seg_scan_driver;

   localparam int unsigned N = 4;
   localparam int unsigned R = 4;
   localparam int unsigned G = 1;

   logic clk_in = 1'b0;
   logic rst    = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   seg_scan_if #(.NUM_DIGITS(N)) bus ();

   seg_scan_driver #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (R),
      .GUARD_CYCLES(G)
   ) dut (
      .clk_in(clk_in),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Called at a frame boundary; the load edge is the slot-0 cnt=0 edge
   task automatic load_word(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
      bus.data_in  = d;
      bus.dp_in    = dp;
      bus.blank_in = bl;
      bus.load     = 1'b1;
      step();
      bus.load     = 1'b0;
   endtask

   // Checks each digit at cnt=1 of its slot; leaves the bench at the next frame boundary
   task automatic frame_check(input string tag, input logic [27:0] seg_e, input logic [3:0] dp_e);
      logic [3:0] an_e;
      for (int k = 0; k < 4; k++) begin
         step();
         an_e    = 4'b1111;
         an_e[k] = 1'b0;
         chk($sformatf("%s an d%0d", tag, k), 32'(bus.an_out), 32'(an_e));
         chk($sformatf("%s seg d%0d", tag, k), 32'(bus.seg_out), 32'(seg_e[7*k +: 7]));
         chk($sformatf("%s dp d%0d", tag, k), 32'(bus.dp_out), 32'(dp_e[k]));
         step();
         step();
         if (k < 3) step();
      end
   endtask

   logic [3:0] an_tbl [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

   initial begin
      bus.load     = 1'b0;
      bus.data_in  = '0;
      bus.dp_in    = '0;
      bus.blank_in = '0;
      bus.lz_en    = 1'b0;

      #1 rst = 1'b1;
      #1;
      chk("rst seg", 32'(bus.seg_out), 32'h7F);
      chk("rst dp", 32'(bus.dp_out), 32'h1);
      chk("rst an", 32'(bus.an_out), 32'hF);
      chk("rst tick", 32'(bus.frame_tick), 32'h0);

      // Load during reset must be ignored
      bus.data_in = 16'hFFFF;
      bus.load    = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      bus.load    = 1'b0;
      bus.data_in = '0;
      rst = 1'b0;

      // Two full frames of scan
      for (int n = 1; n <= 32; n++) begin
         step();
         chk($sformatf("scan an n%0d", n), 32'(bus.an_out), 32'(an_tbl[(n-1) % 16]));
         chk($sformatf("scan tick n%0d", n), 32'(bus.frame_tick),
             ((n == 16) || (n == 32)) ? 32'h1 : 32'h0);
         if (n == 2) chk("scan seg after ignored load", 32'(bus.seg_out), 32'h40);
      end

      // Decode all 16 values; packed {d3,d2,d1,d0}
      load_word(16'h3210, 4'h0, 4'h0);
      frame_check("dec3210", {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF);
      load_word(16'h7654, 4'h0, 4'h0);
      frame_check("dec7654", {7'h78, 7'h02, 7'h12, 7'h19}, 4'hF);
      load_word(16'hBA98, 4'h0, 4'h0);
      frame_check("decBA98", {7'h03, 7'h08, 7'h10, 7'h00}, 4'hF);
      load_word(16'hFEDC, 4'h0, 4'h0);
      frame_check("decFEDC", {7'h0E, 7'h06, 7'h21, 7'h46}, 4'hF);

      // Leading-zero suppression; suppressed digit 3 also hides its dp
      bus.lz_en = 1'b1;
      load_word(16'h0050, 4'b1000, 4'h0);
      frame_check("lz0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
      load_word(16'h0000, 4'h0, 4'h0);
      frame_check("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
      bus.lz_en = 1'b0;

      // Blank digit 0, dp on digit 2
      load_word(16'h1234, 4'b0100, 4'b0001);
      frame_check("blank1234", {7'h79, 7'h24, 7'h30, 7'h7F}, 4'b1011);
      // dp request on a blanked digit stays dark
      load_word(16'h1234, 4'b0101, 4'b0001);
      frame_check("blankdp", {7'h79, 7'h24, 7'h30, 7'h7F}, 4'b1011);

      // Mid-slot load at cnt=2 of digit 0
      step();
      chk("mid cnt0 an", 32'(bus.an_out), 32'hF);
      step();
      chk("mid cnt1 seg", 32'(bus.seg_out), 32'h7F);
      bus.data_in  = 16'h0008;
      bus.dp_in    = '0;
      bus.blank_in = '0;
      bus.load     = 1'b1;
      step();
      bus.load     = 1'b0;
      chk("mid load edge seg", 32'(bus.seg_out), 32'h7F);
      chk("mid load edge an", 32'(bus.an_out), 32'hE);
      step();
      chk("mid +2 seg", 32'(bus.seg_out), 32'h00);
      chk("mid +2 an", 32'(bus.an_out), 32'hE);
      chk("mid +2 dp", 32'(bus.dp_out), 32'h1);
      step();
      chk("mid slot1 guard an", 32'(bus.an_out), 32'hF);

      // Advance to digit 2 and reset asynchronously between edges
      for (int i = 0; i < 5; i++) step();
      chk("pre-rst an d2", 32'(bus.an_out), 32'hB);
      chk("pre-rst seg d2", 32'(bus.seg_out), 32'h40);
      #2 rst = 1'b1;
      #1;
      chk("async rst seg", 32'(bus.seg_out), 32'h7F);
      chk("async rst dp", 32'(bus.dp_out), 32'h1);
      chk("async rst an", 32'(bus.an_out), 32'hF);
      chk("async rst tick", 32'(bus.frame_tick), 32'h0);
      @(negedge clk_in);
      rst = 1'b0;
      step();
      chk("restart guard an", 32'(bus.an_out), 32'hF);
      step();
      chk("restart an d0", 32'(bus.an_out), 32'hE);
      chk("restart seg cleared", 32'(bus.seg_out), 32'h40);
      chk("restart dp", 32'(bus.dp_out), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed N-digit seven-segment display driver that generalises the single-digit hex decoder. It captures a packed hex word on a load strobe and time-multiplexes one shared segment bus across NUM_DIGITS common-anode digits. Per-digit decimal points, per-digit blanking, leading-zero suppression and an anti-ghosting guard interval are included. It sits between the datapath result registers and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 50000, clk_in cycles per digit slot (>= 2)
- GUARD_CYCLES, 2, cycles at slot start with all anodes off (0 <= GUARD_CYCLES < REFRESH_DIV)
- clk_in  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  capture strobe for data_in / dp_in / blank_in
- data_in  input  4*NUM_DIGITS  packed hex digits; digit k = data_in[4k+3:4k]; digit 0 is rightmost
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
- blank_in  input  NUM_DIGITS  force digit dark, 1 = blank
- lz_en  input  1  leading-zero suppression enable (level, sampled live)
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp_out  output  1  decimal point, active-low
- an_out  output  NUM_DIGITS  digit enables, active-low, at most one low
- frame_tick  output  1  one-cycle pulse at end of each full scan

## Operation
- Holding registers (data_q, dp_q, blank_q) load from inputs on any clk_in edge with load=1; otherwise hold. Reset value: all zero.
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, digit index idx advances 0,1,..,NUM_DIGITS-1,0. Reset: cnt=0, idx=0.
- Encoding, active-low, bit order g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Digit k is dark if any of: blank_q[k]=1; lz_en=1, k>=1 and data_q digits k..NUM_DIGITS-1 are all zero. Digit 0 is never zero-suppressed.
- A dark digit drives seg_out=1111111 and dp_out=1. Its an_out bit still follows the scan. A suppressed digit's dp is also dark. A blanked digit's dp is dark.
- Guard interval: while cnt < GUARD_CYCLES, an_out is all ones and seg_out/dp_out = all ones.
- Otherwise an_out[idx]=0 and all other bits are 1. seg_out is the encoding of the selected digit; dp_out = ~dp_q[idx].
- frame_tick=1 for exactly one cycle following the edge where cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1.

## Timing
- seg_out, dp_out, an_out and frame_tick are registered and reflect (cnt, idx, holding regs) of the previous cycle, giving 1-cycle latency.
- Reset values of outputs: seg_out=1111111, dp_out=1, an_out=all ones, frame_tick=0.
- First post-reset enabled digit: with GUARD_CYCLES=G, an_out[0] goes low at output cycle G+1 after rst falls.
- Load to display: a new value appears on seg_out 2 cycles after the load edge if its digit is active. Updates are permitted mid-slot, with no tearing beyond that single change.
- load asserted during rst is ignored. rst asserted mid-slot clears outputs immediately (asynchronously) and restarts the scan at idx 0.
- Full frame period = NUM_DIGITS*REFRESH_DIV cycles.
- lz_en changes take effect with the same 1-cycle output latency.

## Test plan
- Reset/scan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1), stimulus: release rst. Required response:
  - an_out sequence per slot is 1111,1110,1110,1110, then 1111,1101,1101,1101, and so on.
  - frame_tick pulses every 16 cycles.
- Decode all 16 values: load data_in=0x3210, then 0x7654, 0xBA98, 0xFEDC. Required response: each slot's seg_out matches the encoding table, e.g. digit 1 of 0x3210 gives 1111001.
- Leading zero: load 0x0050 with lz_en=1. Required response:
  - Digits 3,2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000.
  - Loading 0x0000 shows only digit 0 as 1000000.
- Blank/dp: load 0x1234 with dp_in=0100 and blank_in=0001. Required response:
  - Digit 2 has dp_out=0.
  - Digit 0 shows seg_out=1111111, dp_out=1.
- Mid-slot load: load 0x0008 during digit 0 slot at cnt=2. Required response: seg_out changes to 0000000 exactly 2 cycles later with no anode glitch.
- Async reset mid-scan: assert rst between clock edges during idx=2. Required response:
  - Outputs go to reset values before the next edge.
  - After release, the scan restarts at digit 0 and the holding registers read zero.
